// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//
// Digit-serial adder/subtractor. Each accepted operation walks the latched
// operands from LSB to MSB, DIGIT bits per clock, linking digits through one
// registered carry/borrow bit. An operation takes N = WIDTH/DIGIT cycles.
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 1)
//   DIGIT  bits processed per cycle; must divide WIDTH exactly
//
// Ports:
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   request; sampled only when not busy (IDLE or DONE)
//   mode      in   0 = add (a + b + cin), 1 = subtract (a - b - cin)
//   a         in   operand A (minuend in subtract mode)
//   b         in   operand B (subtrahend in subtract mode)
//   cin       in   carry-in (add) or borrow-in (subtract)
//   busy      out  operation in progress
//   done      out  one-cycle pulse; result/cout/overflow valid from this cycle
//   result    out  sum or difference modulo 2^WIDTH
//   cout      out  carry-out (add) or borrow-out (subtract)
//   overflow  out  two's-complement signed overflow
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [CNT_W-1:0] LAST_CNT   = CNT_W'(N - 1);
  localparam logic [WIDTH-1:0] DIGIT_MASK = WIDTH'({DIGIT{1'b1}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {carry_out, sum} of one digit plus carry.
  function automatic logic [DIGIT:0] digit_add(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    digit_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, c};
  endfunction

  // Returns {borrow_out, difference}. Working in DIGIT+1 bits, the top bit of
  // the wrapped difference is set exactly when x < y + c.
  function automatic logic [DIGIT:0] digit_sub(
    input logic [DIGIT-1:0] x,
    input logic [DIGIT-1:0] y,
    input logic             c
  );
    digit_sub = {1'b0, x} - {1'b0, y} - {{DIGIT{1'b0}}, c};
  endfunction

  // Signed overflow from operand and result sign bits.
  function automatic logic signed_ovf(
    input logic sub,
    input logic a_msb,
    input logic b_msb,
    input logic r_msb
  );
    if (sub) begin
      signed_ovf = (a_msb != b_msb) && (r_msb != a_msb);
    end else begin
      signed_ovf = (a_msb == b_msb) && (r_msb != a_msb);
    end
  endfunction

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               mode_q, mode_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               overflow_q, overflow_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               accept_s;
  logic               last_s;
  logic [31:0]        base_s;
  logic [DIGIT-1:0]   a_dig_s;
  logic [DIGIT-1:0]   b_dig_s;
  logic [DIGIT:0]     dig_res_s;

  // A start is only honoured while not busy; DONE also accepts to allow
  // back-to-back operations without an IDLE gap.
  assign accept_s = start && ((state_q == IDLE) || (state_q == DONE));
  assign last_s   = (state_q == RUN) && (cnt_q == LAST_CNT);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (start) begin
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Current digit of each latched operand and its add/subtract result.
  always_comb begin
    base_s  = 32'(cnt_q) * 32'(DIGIT);
    a_dig_s = DIGIT'(a_q >> base_s);
    b_dig_s = DIGIT'(b_q >> base_s);
    if (mode_q) begin
      dig_res_s = digit_sub(a_dig_s, b_dig_s, carry_q);
    end else begin
      dig_res_s = digit_add(a_dig_s, b_dig_s, carry_q);
    end
  end

  // Output and datapath next-values.
  always_comb begin
    a_d        = a_q;
    b_d        = b_q;
    mode_d     = mode_q;
    carry_d    = carry_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    cout_d     = cout_q;
    overflow_d = overflow_q;

    if (accept_s) begin
      // Operands are captured here so later input changes cannot disturb
      // the operation. result/cout/overflow keep their old values until
      // overwritten digit by digit.
      a_d     = a;
      b_d     = b;
      mode_d  = mode;
      carry_d = cin;
      cnt_d   = {CNT_W{1'b0}};
    end else if (state_q == RUN) begin
      // Splice the new digit into its final position in result.
      result_d = (result_q & ~(DIGIT_MASK << base_s))
               | (WIDTH'(dig_res_s[DIGIT-1:0]) << base_s);
      carry_d  = dig_res_s[DIGIT];
      cnt_d    = cnt_q + CNT_W'(1);
      if (last_s) begin
        // The digit just produced holds the result MSB.
        cout_d     = dig_res_s[DIGIT];
        overflow_d = signed_ovf(mode_q, a_q[WIDTH-1], b_q[WIDTH-1],
                                dig_res_s[DIGIT-1]);
      end else begin
        cout_d     = cout_q;
        overflow_d = overflow_q;
      end
    end else begin
      result_d = result_q;
      carry_d  = carry_q;
    end

    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      mode_q     <= 1'b0;
      carry_q    <= 1'b0;
      cnt_q      <= {CNT_W{1'b0}};
      result_q   <= {WIDTH{1'b0}};
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      a_q        <= a_d;
      b_q        <= b_d;
      mode_q     <= mode_d;
      carry_q    <= carry_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      cout_q     <= cout_d;
      overflow_q <= overflow_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//
// Three instances of serial_addsub (1/1, 8/1, 8/4 for WIDTH/DIGIT) driven with
// directed and random operations, checked against an arithmetic reference.
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  logic clk;
  logic rst_n;

  // Instance 0: WIDTH=1, DIGIT=1
  logic start0, mode0, a0, b0, cin0, busy0, done0, res0, cout0, ovf0;
  // Instance 1: WIDTH=8, DIGIT=1
  logic start1, mode1, cin1, busy1, done1, cout1, ovf1;
  logic [7:0] a1, b1, res1;
  // Instance 2: WIDTH=8, DIGIT=4
  logic start2, mode2, cin2, busy2, done2, cout2, ovf2;
  logic [7:0] a2, b2, res2;

  serial_addsub #(.WIDTH(1), .DIGIT(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .mode(mode0), .a(a0), .b(b0),
    .cin(cin0), .busy(busy0), .done(done0), .result(res0), .cout(cout0),
    .overflow(ovf0)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .mode(mode1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .result(res1), .cout(cout1),
    .overflow(ovf1)
  );

  serial_addsub #(.WIDTH(8), .DIGIT(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .mode(mode2), .a(a2), .b(b2),
    .cin(cin2), .busy(busy2), .done(done2), .result(res2), .cout(cout2),
    .overflow(ovf2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int lat_cnt  = 0;

  int w_of [3] = '{1, 8, 8};
  int n_of [3] = '{1, 8, 2};

  logic [7:0] ex_a, ex_b;
  logic       ex_m, ex_c;
  logic [7:0] last_r;
  logic       last_co;

  logic       ob, od, oco, oov;
  logic [7:0] ores;

  task automatic chk_eq(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on a w-bit word.
  function automatic void ref_op(input int w, input logic [7:0] av,
                                 input logic [7:0] bv, input logic m,
                                 input logic cv, output logic [7:0] r,
                                 output logic co, output logic ov);
    longint mask = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua = longint'(av) & mask;
    longint ub = longint'(bv) & mask;
    longint uc = longint'(cv);
    longint full, sa, sb, sf;
    if (m) begin
      full = ua - ub - uc;
      co   = (ua < ub + uc);
    end else begin
      full = ua + ub + uc;
      co   = ((full >> w) & 1) != 0;
    end
    r  = 8'(full & mask);
    sa = (ua >= half) ? ua - (mask + 1) : ua;
    sb = (ub >= half) ? ub - (mask + 1) : ub;
    sf = m ? (sa - sb - uc) : (sa + sb + uc);
    ov = (sf < -half) || (sf > half - 1);
  endfunction

  task automatic set_in(input int sel, input logic st, input logic m,
                        input logic [7:0] av, input logic [7:0] bv,
                        input logic cv);
    case (sel)
      0: begin start0 = st; mode0 = m; a0 = av[0]; b0 = bv[0]; cin0 = cv; end
      1: begin start1 = st; mode1 = m; a1 = av;    b1 = bv;    cin1 = cv; end
      default: begin start2 = st; mode2 = m; a2 = av; b2 = bv; cin2 = cv; end
    endcase
  endtask

  task automatic get_out(input int sel);
    case (sel)
      0: begin ob = busy0; od = done0; ores = {7'd0, res0}; oco = cout0; oov = ovf0; end
      1: begin ob = busy1; od = done1; ores = res1; oco = cout1; oov = ovf1; end
      default: begin ob = busy2; od = done2; ores = res2; oco = cout2; oov = ovf2; end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lat_cnt++;
  endtask

  task automatic check_zero(input int sel, input string tag);
    get_out(sel);
    chk_eq({tag, "_busy"}, ob, 0);
    chk_eq({tag, "_done"}, od, 0);
    chk_eq({tag, "_result"}, ores, 0);
    chk_eq({tag, "_cout"}, oco, 0);
    chk_eq({tag, "_ovf"}, oov, 0);
  endtask

  // Present a request, let it be sampled (E0), then scramble the inputs.
  task automatic start_op(input int sel, input logic [7:0] av,
                          input logic [7:0] bv, input logic m, input logic cv);
    set_in(sel, 1'b1, m, av, bv, cv);
    ex_a = av; ex_b = bv; ex_m = m; ex_c = cv;
    tick();
    lat_cnt = 0;
    set_in(sel, 1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
    get_out(sel);
    chk_eq("busy_after_start", ob, 1);
    chk_eq("done_after_start", od, 0);
  endtask

  // Wait (bounded) for done, then compare latency and results.
  task automatic finish_op(input int sel);
    logic [7:0] r;
    logic       co, ov;
    get_out(sel);
    while (!od && lat_cnt < 40) begin
      tick();
      get_out(sel);
    end
    ref_op(w_of[sel], ex_a, ex_b, ex_m, ex_c, r, co, ov);
    chk_eq("latency", lat_cnt, n_of[sel]);
    chk_eq("done", od, 1);
    chk_eq("busy_in_done", ob, 0);
    chk_eq("result", ores, r);
    chk_eq("cout", oco, co);
    chk_eq("overflow", oov, ov);
    last_r  = r;
    last_co = co;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    set_in(0, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    set_in(1, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    set_in(2, 1'b0, 1'b0, 8'd0, 8'd0, 1'b0);
    #12;
    for (int s = 0; s < 3; s++) check_zero(s, "reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Full-subtractor truth table on the 1-bit instance.
    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      start_op(0, {7'd0, v[2]}, {7'd0, v[1]}, 1'b1, v[0]);
      finish_op(0);
      chk_eq("fs_diff", ores[0], v[2] ^ v[1] ^ v[0]);
      chk_eq("fs_borrow", oco, (~v[2] & v[1]) | (~(v[2] ^ v[1]) & v[0]));
      tick();
    end

    // Directed 8-bit, 1-bit-digit cases.
    start_op(1, 8'h05, 8'h03, 1'b1, 1'b0); finish_op(1);
    chk_eq("sub_05_03", ores, 8'h02);
    start_op(1, 8'h03, 8'h05, 1'b1, 1'b0); finish_op(1);
    chk_eq("sub_03_05", ores, 8'hFE);
    chk_eq("sub_03_05_borrow", oco, 1);
    start_op(1, 8'h80, 8'h01, 1'b1, 1'b0); finish_op(1);
    chk_eq("sub_80_01_ovf", oov, 1);
    start_op(1, 8'hFF, 8'h01, 1'b0, 1'b0); finish_op(1);
    chk_eq("add_ff_01_carry", oco, 1);
    start_op(1, 8'h7F, 8'h01, 1'b0, 1'b0); finish_op(1);
    chk_eq("add_7f_01", ores, 8'h80);
    tick();

    // 4-bit digits, then a back-to-back request issued in the DONE cycle.
    start_op(2, 8'h3C, 8'h4B, 1'b0, 1'b1); finish_op(2);
    chk_eq("add_3c_4b", ores, 8'h88);
    chk_eq("add_3c_4b_ovf", oov, 1);
    start_op(2, 8'hA5, 8'h5A, 1'b1, 1'b1); finish_op(2);
    tick();

    // Start pulsed mid-operation must be ignored.
    start_op(1, 8'h10, 8'h01, 1'b1, 1'b0);
    tick(); tick();
    set_in(1, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1);
    tick();
    set_in(1, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    get_out(1);
    chk_eq("busy_after_ignored_start", ob, 1);
    finish_op(1);
    chk_eq("ignored_start_result", ores, 8'h0F);
    tick();
    get_out(1);
    chk_eq("no_phantom_op", ob, 0);
    chk_eq("hold_after_done", ores, 8'h0F);

    // Asynchronous reset in the middle of an operation.
    start_op(1, 8'hFF, 8'h00, 1'b0, 1'b0);
    tick(); tick(); tick();
    get_out(1);
    chk_eq("partial_result_nonzero", (ores != 8'h00), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero(1, "async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    start_op(1, 8'h09, 8'h09, 1'b1, 1'b0); finish_op(1);
    chk_eq("after_reset_result", ores, 8'h00);
    tick();

    // Random operations with random idle gaps (gap 0 = back-to-back).
    for (int s = 0; s < 3; s++) begin
      for (int j = 0; j < 30; j++) begin
        int gap;
        gap = (j == 0) ? 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < gap; g++) tick();
        if (j > 0 && gap > 0) begin
          get_out(s);
          chk_eq("rand_hold_result", ores, last_r);
          chk_eq("rand_hold_cout", oco, last_co);
          chk_eq("rand_idle_done", od, 0);
        end
        start_op(s, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
        finish_op(s);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
